// File: rtl/int_tx_ascii_pkg.sv
// Shared definitions for the UART calculator link.
// Holds the TX-side state encoding and ASCII byte constants next to the RX
// operator codes, so both directions decode the same table.
package int_tx_ascii_pkg;

  // TX formatter states; the numeric values are visible on the STATE debug port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SIGN   = 3'd2,
    ST_DIGIT  = 3'd3,
    ST_CR     = 3'd4,
    ST_LF     = 3'd5,
    ST_FINISH = 3'd6
  } tx_state_e;

  // ASCII bytes emitted on the TX path
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Operator bytes recognised on the RX path
  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;
  localparam logic [7:0] OP_EQ  = 8'h3D;

  // Double-dabble correction: a nibble >= 5 would overflow past 9 after the
  // next shift, so pre-add 3 to carry into the next decade.
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/int_tx_ascii_bin2bcd.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       one-cycle load of bin; restarts any conversion in progress
//   bin         unsigned binary input, NBIT bits
//   bcd         DIGITS packed BCD nibbles, LSD in [3:0]; final once done pulses
//   done        one-cycle pulse; bcd is valid from this cycle on
// The load edge performs the first (trivial) iteration, so the full NBIT
// iterations finish NBIT edges after start and done is seen one cycle later.
module bin2bcd_seq
  import int_tx_ascii_pkg::*;
#(
  parameter int NBIT   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NBIT-1:0]       bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CW = $clog2(NBIT + 1);

  logic [NBIT-1:0]           sh;
  logic [CW-1:0]             cnt;
  logic                      run;
  logic [DIGITS-1:0][3:0]    adj;
  logic [4*DIGITS-1:0]       adj_flat;

  // per-nibble add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[g] = dd_adj(bcd[4*g +: 4]);
  end
  assign adj_flat = adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd  <= '0;
      sh   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // iteration 1: BCD is zero so no correction, just shift in the MSB
        bcd <= {{(4*DIGITS-1){1'b0}}, bin[NBIT-1]};
        sh  <= {bin[NBIT-2:0], 1'b0};
        cnt <= CW'(NBIT - 1);
        run <= 1'b1;
      end else if (run) begin
        bcd <= {adj_flat[4*DIGITS-2:0], sh[NBIT-1]};
        sh  <= {sh[NBIT-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/int_tx_ascii.sv
// int_tx_ascii: formats the ALU result as ASCII decimal for the UART TX FIFO.
// Frame: ['-'] digits (MSD first, no leading zeros) [CR LF].
// Ports:
//   CLK, RESET_N  clock, async active-low reset
//   START         request pulse from RX FIN; only honoured in IDLE
//   RESULT        ALU result, captured on the accepted START
//   FIFO_full     TX FIFO full; stalls the frame with data_out held
//   WR_FIFO       write strobe, one byte per high cycle
//   data_out      byte to the FIFO, valid while WR_FIFO=1
//   BUSY          high from the cycle after an accepted START until IDLE
//   DONE          one-cycle pulse after the last byte is written
//   STATE         current state, debug
module int_tx_ascii
  import int_tx_ascii_pkg::*;
#(
  parameter int NBIT   = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1,
  parameter int EOL_EN = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [NBIT-1:0] RESULT,
  input  logic            FIFO_full,
  output logic            WR_FIFO,
  output logic [7:0]      data_out,
  output logic            BUSY,
  output logic            DONE,
  output logic [2:0]      STATE
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  tx_state_e              state;
  logic                   neg;
  logic [PW-1:0]          ptr;
  logic                   res_neg;
  logic [NBIT-1:0]        mag;
  logic                   cvt_start;
  logic [4*DIGITS-1:0]    bcd;
  logic [DIGITS-1:0][3:0] bcd_d;
  logic                   bcd_done;
  logic [3:0]             cur_digit;
  logic                   send;

  // magnitude of the result; two's-complement negate maps -2**(NBIT-1) to
  // 2**(NBIT-1), which still fits unsigned in NBIT bits
  assign res_neg   = (SIGNED != 0) && RESULT[NBIT-1];
  assign mag       = res_neg ? (~RESULT + 1'b1) : RESULT;
  assign cvt_start = (state == ST_IDLE) && START;

  bin2bcd_seq #(
    .NBIT   (NBIT),
    .DIGITS (DIGITS)
  ) u_b2b (
    .clk   (CLK),
    .rst_n (RESET_N),
    .start (cvt_start),
    .bin   (mag),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  assign bcd_d     = bcd;
  assign cur_digit = bcd_d[ptr];

  // index of the most significant non-zero digit; 0 when all zero so the
  // value 0 still prints one '0'
  function automatic logic [PW-1:0] msd_ptr(input logic [DIGITS-1:0][3:0] d);
    msd_ptr = '0;
    for (int i = 0; i < DIGITS; i++)
      if (d[i] != 4'd0) msd_ptr = PW'(i);
  endfunction

  assign send    = (state == ST_SIGN) || (state == ST_DIGIT) ||
                   (state == ST_CR)   || (state == ST_LF);
  // write as soon as there is room; the FSM only advances on a real write
  assign WR_FIFO = send && !FIFO_full;
  assign STATE   = state;

  always_comb begin
    data_out = 8'h00;
    case (state)
      ST_SIGN:  data_out = ASCII_MINUS;
      ST_DIGIT: data_out = ASCII_ZERO + {4'h0, cur_digit};
      ST_CR:    data_out = ASCII_CR;
      ST_LF:    data_out = ASCII_LF;
      default:  data_out = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      neg   <= 1'b0;
      ptr   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            neg   <= res_neg;
            BUSY  <= 1'b1;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            ptr   <= msd_ptr(bcd_d);
            state <= neg ? ST_SIGN : ST_DIGIT;
          end
        end
        ST_SIGN: begin
          if (WR_FIFO) state <= ST_DIGIT;
        end
        ST_DIGIT: begin
          if (WR_FIFO) begin
            if (ptr == '0) begin
              if (EOL_EN != 0) begin
                state <= ST_CR;
              end else begin
                state <= ST_FINISH;
                DONE  <= 1'b1;
              end
            end else begin
              ptr <= ptr - 1'b1;
            end
          end
        end
        ST_CR: begin
          if (WR_FIFO) state <= ST_LF;
        end
        ST_LF: begin
          if (WR_FIFO) begin
            state <= ST_FINISH;
            DONE  <= 1'b1;
          end
        end
        ST_FINISH: begin
          // START here is deliberately dropped; no request queueing
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_tx_ascii.sv
// Bench for int_tx_ascii: a signed instance (u_s) and an unsigned instance
// (u_u) share all inputs. The model renders each captured RESULT as its
// expected ASCII frame with integer division; one negedge process checks
// every write, every DONE level and the no-write-while-full rule.
module tb_int_tx_ascii;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic [7:0] RESULT;
  logic       FIFO_full;

  logic       wr   [2];
  logic [7:0] dout [2];
  logic       busy [2];
  logic       done [2];
  logic [2:0] st   [2];

  int vectors = 0;
  int miscompares = 0;

  // model: expected frame per instance, byte i at [8*i +: 8]
  logic [63:0] frm [2];
  int          len [2];
  int          idx [2];
  logic        done_exp [2];

  int_tx_ascii #(.NBIT(8), .DIGITS(3), .SIGNED(1), .EOL_EN(1)) u_s (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .RESULT(RESULT),
    .FIFO_full(FIFO_full), .WR_FIFO(wr[0]), .data_out(dout[0]),
    .BUSY(busy[0]), .DONE(done[0]), .STATE(st[0])
  );

  int_tx_ascii #(.NBIT(8), .DIGITS(3), .SIGNED(0), .EOL_EN(1)) u_u (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .RESULT(RESULT),
    .FIFO_full(FIFO_full), .WR_FIFO(wr[1]), .data_out(dout[1]),
    .BUSY(busy[1]), .DONE(done[1]), .STATE(st[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // decimal rendering of a byte value as the FIFO should receive it
  function automatic logic [63:0] build(input logic [7:0] v, input bit sgn, output int n);
    logic [63:0] f;
    int mag;
    int dg [3];
    int nd;
    f = '0;
    n = 0;
    mag = int'(v);
    if (sgn && v[7]) begin
      mag = 256 - int'(v);
      f[8*n +: 8] = 8'h2D; n++;
    end
    nd = 0;
    do begin
      dg[nd] = mag % 10;
      mag = mag / 10;
      nd++;
    end while (mag > 0);
    for (int i = nd - 1; i >= 0; i--) begin
      f[8*n +: 8] = 8'h30 + 8'(dg[i]); n++;
    end
    f[8*n +: 8] = 8'h0D; n++;
    f[8*n +: 8] = 8'h0A; n++;
    return f;
  endfunction

  // per-cycle compare against the model
  always @(negedge CLK) begin
    if (!RESET_N) begin
      for (int k = 0; k < 2; k++) begin
        idx[k] = len[k];
        done_exp[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk("done", k, 32'(done[k]), 32'(done_exp[k]));
        done_exp[k] = 1'b0;
        if (FIFO_full) chk("wr_while_full", k, 32'(wr[k]), 32'd0);
        if (wr[k]) begin
          if (idx[k] >= len[k]) begin
            chk("spurious_wr", k, 32'(wr[k]), 32'd0);
          end else begin
            chk("byte", k, 32'(dout[k]), 32'(frm[k][8*idx[k] +: 8]));
            idx[k]++;
            if (idx[k] == len[k]) done_exp[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic start_frame(input logic [7:0] v, input bit model);
    RESULT = v;
    START  = 1'b1;
    if (model) begin
      for (int k = 0; k < 2; k++) begin
        frm[k] = build(v, (k == 0), len[k]);
        idx[k] = 0;
      end
    end
    @(posedge CLK); #1;
    START  = 1'b0;
    RESULT = v ^ 8'h5A;   // must not affect the captured frame
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (idx[0] == len[0] && idx[1] == len[1] && st[0] == 3'd0 && st[1] == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 0, 32'(ok), 32'd1);
    for (int k = 0; k < 2; k++) chk("busy_end", k, 32'(busy[k]), 32'd0);
  endtask

  // cycles from the accepted START edge to the first sampled write
  task automatic check_latency();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!wr[0] && n < 40);
    chk("latency", 0, 32'(n), 32'd9);
  endtask

  task automatic wait_byte(input logic [7:0] b);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (wr[0] && dout[0] == b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("byte_timeout", 0, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [63:0] f;
    int n;
    RESET_N = 1'b0; START = 1'b0; RESULT = 8'h00; FIFO_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      len[k] = 0; idx[k] = 0; done_exp[k] = 1'b0; frm[k] = '0;
    end

    // pin the model with hand-computed frames (bytes listed last-first)
    f = build(8'h00, 1'b0, n); chk("model_0",    0, f[31:0], 32'h000A0D30);   chk("model_0_len", 0, 32'(n), 32'd3);
    f = build(8'hFF, 1'b0, n); chk("model_ff",   0, f[31:0], 32'h0D353532);   chk("model_ff_len", 0, 32'(n), 32'd5);
    f = build(8'h80, 1'b1, n); chk("model_m128", 0, f[31:0], 32'h3832312D);   chk("model_m128_hi", 0, {16'h0, f[47:32]}, 32'h00000A0D);
    f = build(8'h07, 1'b1, n); chk("model_7",    0, f[31:0], 32'h000A0D37);

    // reset state
    repeat (2) @(posedge CLK); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_wr",   k, 32'(wr[k]),   32'd0);
      chk("rst_data", k, 32'(dout[k]), 32'd0);
      chk("rst_busy", k, 32'(busy[k]), 32'd0);
      chk("rst_done", k, 32'(done[k]), 32'd0);
      chk("rst_state", k, 32'(st[k]),  32'd0);
    end
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // zero, 255 (-1 signed), -128 (128 unsigned), 7
    start_frame(8'h00, 1'b1);
    for (int k = 0; k < 2; k++) chk("busy_run", k, 32'(busy[k]), 32'd1);
    check_latency();
    wait_idle();
    start_frame(8'hFF, 1'b1); check_latency(); wait_idle();
    start_frame(8'h80, 1'b1); check_latency(); wait_idle();
    start_frame(8'h07, 1'b1); wait_idle();

    // FIFO full from the '4' write cycle for 5 cycles
    start_frame(8'd42, 1'b1);
    repeat (8) @(posedge CLK); #1;
    FIFO_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        chk("stall_wr",   k, 32'(wr[k]),   32'd0);
        chk("stall_data", k, 32'(dout[k]), 32'h34);
      end
    end
    @(posedge CLK); #1;
    FIFO_full = 1'b0;
    wait_idle();

    // START during CONV and during DIGIT must be ignored
    start_frame(8'd100, 1'b1);
    repeat (3) @(posedge CLK); #1;
    start_frame(8'd55, 1'b0);
    wait_byte(8'h31);
    @(posedge CLK); #1;
    start_frame(8'd200, 1'b0);
    wait_idle();
    repeat (20) @(negedge CLK);
    for (int k = 0; k < 2; k++) chk("no_second_frame", k, 32'(st[k]), 32'd0);

    // reset right after the first digit write drops the frame
    start_frame(8'h80, 1'b1);
    wait_byte(8'h31);
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_wr",    k, 32'(wr[k]),   32'd0);
      chk("mid_rst_state", k, 32'(st[k]),   32'd0);
      chk("mid_rst_done",  k, 32'(done[k]), 32'd0);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    @(posedge CLK); #1;
    start_frame(8'h80, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
